// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: program counter, I-cache address and IF/ID latch.
// The optional perf counters are built in when IF_PERF_CNT_EN is defined.
module if_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        jump,
  input  logic [15:0] jump_target,
  input  logic        i_hit,
  input  logic [15:0] instr_i,
  output logic [15:0] i_addr,
  output logic        i_rd_en,
  output logic [15:0] instr_id,
  output logic [15:0] pc_id,
  output logic [15:0] pc_plus1_id,
  output logic        valid_id
`ifdef IF_PERF_CNT_EN
  ,
  input  logic        perf_clr,
  output logic [15:0] perf_fetch_cnt,
  output logic [15:0] perf_miss_cnt
`endif
);

  typedef enum logic [1:0] {StBoot, StFetch, StMiss} state_e;

  localparam logic [15:0] Nop = 16'h0000;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_id_q, instr_id_d;
  logic [15:0] pc_id_q, pc_id_d;
  logic [15:0] pc_plus1_id_q, pc_plus1_id_d;
  logic        valid_id_q, valid_id_d;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_id_d    = instr_id_q;
    pc_id_d       = pc_id_q;
    pc_plus1_id_d = pc_plus1_id_q;
    valid_id_d    = valid_id_q;
    case (state_q)
      StBoot: begin
        // Boot cycle ignores stall and jump: bubble out, PC held.
        instr_id_d = Nop;
        valid_id_d = 1'b0;
        state_d    = StFetch;
      end
      StFetch, StMiss: begin
        if (jump) begin
          pc_d       = jump_target;
          instr_id_d = Nop;
          valid_id_d = 1'b0;
          state_d    = StFetch;
        end else if (stall) begin
          state_d = state_q;
        end else if (!i_hit) begin
          instr_id_d = Nop;
          valid_id_d = 1'b0;
          state_d    = StMiss;
        end else begin
          instr_id_d    = instr_i;
          pc_id_d       = pc_q;
          pc_plus1_id_d = pc_q + 16'd1;
          valid_id_d    = 1'b1;
          pc_d          = pc_q + 16'd1;
          state_d       = StFetch;
        end
      end
      default: begin
        state_d = StBoot;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StBoot;
      pc_q          <= RESET_PC;
      instr_id_q    <= Nop;
      pc_id_q       <= RESET_PC;
      pc_plus1_id_q <= RESET_PC + 16'd1;
      valid_id_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_id_q    <= instr_id_d;
      pc_id_q       <= pc_id_d;
      pc_plus1_id_q <= pc_plus1_id_d;
      valid_id_q    <= valid_id_d;
    end
  end

  assign i_addr      = pc_q;
  assign i_rd_en     = (state_q != StBoot);
  assign instr_id    = instr_id_q;
  assign pc_id       = pc_id_q;
  assign pc_plus1_id = pc_plus1_id_q;
  assign valid_id    = valid_id_q;

`ifdef IF_PERF_CNT_EN
  logic        fetch_load, miss_cycle;
  logic [15:0] fetch_cnt_q, fetch_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  // Stall and jump already exclude both events, so counters hold during stall.
  assign fetch_load = (state_q != StBoot) && !jump && !stall && i_hit;
  assign miss_cycle = (state_q != StBoot) && !jump && !stall && !i_hit;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    if (perf_clr) begin
      fetch_cnt_d = 16'h0000;
      miss_cnt_d  = 16'h0000;
    end else begin
      if (fetch_load && (fetch_cnt_q != 16'hFFFF)) fetch_cnt_d = fetch_cnt_q + 16'd1;
      if (miss_cycle && (miss_cnt_q != 16'hFFFF)) miss_cnt_d = miss_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= 16'h0000;
      miss_cnt_q  <= 16'h0000;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_miss_cnt  = miss_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed vector table, hand sequences for reset/wrap,
// and randomized traffic checked against a transaction-level model.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, jump, i_hit, perf_clr;
  logic [15:0] jump_target, instr_i;

  logic [15:0] a_addr, a_instr, a_pcid, a_pp1;
  logic        a_rden, a_valid;
  logic [15:0] w_addr, w_instr, w_pcid, w_pp1;
  logic        w_rden, w_valid;
`ifdef IF_PERF_CNT_EN
  logic [15:0] a_fcnt, a_mcnt, w_fcnt, w_mcnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(16'h0000)) u_dut (
    .clk(clk), .rst(rst), .stall(stall), .jump(jump), .jump_target(jump_target),
    .i_hit(i_hit), .instr_i(instr_i), .i_addr(a_addr), .i_rd_en(a_rden),
    .instr_id(a_instr), .pc_id(a_pcid), .pc_plus1_id(a_pp1), .valid_id(a_valid)
`ifdef IF_PERF_CNT_EN
    , .perf_clr(perf_clr), .perf_fetch_cnt(a_fcnt), .perf_miss_cnt(a_mcnt)
`endif
  );

  if_fetch_unit #(.RESET_PC(16'hFFFF)) u_wrap (
    .clk(clk), .rst(rst), .stall(stall), .jump(jump), .jump_target(jump_target),
    .i_hit(i_hit), .instr_i(instr_i), .i_addr(w_addr), .i_rd_en(w_rden),
    .instr_id(w_instr), .pc_id(w_pcid), .pc_plus1_id(w_pp1), .valid_id(w_valid)
`ifdef IF_PERF_CNT_EN
    , .perf_clr(perf_clr), .perf_fetch_cnt(w_fcnt), .perf_miss_cnt(w_mcnt)
`endif
  );

  // Reference model: architectural view of the stage, one record per DUT.
  typedef struct {
    int   pc;
    bit   boot;
    int   instr;
    int   pcid;
    int   pp1;
    bit   valid;
    int   fetch;
    int   miss;
  } mdl_t;

  mdl_t m0, m1;

  function automatic mdl_t mdl_reset(int rpc);
    mdl_t m;
    m.pc = rpc; m.boot = 1; m.instr = 0; m.pcid = rpc; m.pp1 = (rpc + 1) % 65536;
    m.valid = 0; m.fetch = 0; m.miss = 0;
    return m;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, bit st, bit jp, int tg, bit hit, int din, bit clr);
    mdl_t n = m;
    if (m.boot) begin
      n.boot = 0; n.instr = 0; n.valid = 0;
    end else if (jp) begin
      n.pc = tg; n.instr = 0; n.valid = 0;
    end else if (!st) begin
      if (!hit) begin
        n.instr = 0; n.valid = 0;
        if (m.miss < 65535) n.miss = m.miss + 1;
      end else begin
        n.instr = din; n.pcid = m.pc; n.pp1 = (m.pc + 1) % 65536; n.valid = 1;
        n.pc = (m.pc + 1) % 65536;
        if (m.fetch < 65535) n.fetch = m.fetch + 1;
      end
    end
    if (clr) begin
      n.fetch = 0; n.miss = 0;
    end
    return n;
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_dut(string tag, mdl_t m, logic [15:0] addr, logic rden, logic [15:0] ins,
                         logic [15:0] pcid, logic [15:0] pp1, logic valid,
                         logic [15:0] fcnt, logic [15:0] mcnt);
    chk({tag, ".i_addr"}, addr, 16'(m.pc));
    chk({tag, ".i_rd_en"}, {15'd0, rden}, {15'd0, !m.boot});
    chk({tag, ".instr_id"}, ins, 16'(m.instr));
    chk({tag, ".pc_id"}, pcid, 16'(m.pcid));
    chk({tag, ".pc_plus1_id"}, pp1, 16'(m.pp1));
    chk({tag, ".valid_id"}, {15'd0, valid}, {15'd0, m.valid});
`ifdef IF_PERF_CNT_EN
    chk({tag, ".perf_fetch_cnt"}, fcnt, 16'(m.fetch));
    chk({tag, ".perf_miss_cnt"}, mcnt, 16'(m.miss));
`endif
  endtask

  task automatic check_models();
`ifdef IF_PERF_CNT_EN
    chk_dut("mdl0", m0, a_addr, a_rden, a_instr, a_pcid, a_pp1, a_valid, a_fcnt, a_mcnt);
    chk_dut("mdl1", m1, w_addr, w_rden, w_instr, w_pcid, w_pp1, w_valid, w_fcnt, w_mcnt);
`else
    chk_dut("mdl0", m0, a_addr, a_rden, a_instr, a_pcid, a_pp1, a_valid, 16'h0, 16'h0);
    chk_dut("mdl1", m1, w_addr, w_rden, w_instr, w_pcid, w_pp1, w_valid, 16'h0, 16'h0);
`endif
  endtask

  // One clock edge: advance both models from the inputs seen at the edge, then compare.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      m0 = mdl_reset(16'h0000);
      m1 = mdl_reset(16'hFFFF);
    end else begin
      m0 = mdl_step(m0, stall, jump, jump_target, i_hit, instr_i, perf_clr);
      m1 = mdl_step(m1, stall, jump, jump_target, i_hit, instr_i, perf_clr);
    end
    #1;
    check_models();
  endtask

  task automatic chk_reset_vals();
    chk("rst.i_addr", a_addr, 16'h0000);
    chk("rst.i_rd_en", {15'd0, a_rden}, 16'h0000);
    chk("rst.instr_id", a_instr, 16'h0000);
    chk("rst.pc_id", a_pcid, 16'h0000);
    chk("rst.pc_plus1_id", a_pp1, 16'h0001);
    chk("rst.valid_id", {15'd0, a_valid}, 16'h0000);
    chk("rst.wrap_i_addr", w_addr, 16'hFFFF);
    chk("rst.wrap_pc_plus1_id", w_pp1, 16'h0000);
  endtask

  typedef struct {
    logic        st;
    logic        jp;
    logic [15:0] tg;
    logic        hit;
    logic [15:0] din;
    logic [15:0] e_instr;
    logic [15:0] e_pcid;
    logic [15:0] e_pp1;
    logic        e_valid;
    logic [15:0] e_addr;
    logic [15:0] e_fetch;
    logic [15:0] e_miss;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //        st    jp    tg       hit   din      instr    pcid     pp1     v     addr     fetch  miss
    tbl[0]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h1234, 16'h0000, 16'h0000, 16'h0001, 1'b0, 16'h0000, 16'd0, 16'd0};
    tbl[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h1234, 16'h1234, 16'h0000, 16'h0001, 1'b1, 16'h0001, 16'd1, 16'd0};
    tbl[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h5678, 16'h5678, 16'h0001, 16'h0002, 1'b1, 16'h0002, 16'd2, 16'd0};
    tbl[3]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'hAAAA, 16'h5678, 16'h0001, 16'h0002, 1'b1, 16'h0002, 16'd2, 16'd0};
    tbl[4]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'hBBBB, 16'h5678, 16'h0001, 16'h0002, 1'b1, 16'h0002, 16'd2, 16'd0};
    tbl[5]  = '{1'b0, 1'b1, 16'h0010, 1'b1, 16'hCCCC, 16'h0000, 16'h0001, 16'h0002, 1'b0, 16'h0010, 16'd2, 16'd0};
    tbl[6]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'hDDDD, 16'h0000, 16'h0001, 16'h0002, 1'b0, 16'h0010, 16'd2, 16'd1};
    tbl[7]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'hDDDD, 16'h0000, 16'h0001, 16'h0002, 1'b0, 16'h0010, 16'd2, 16'd2};
    tbl[8]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'hDDDD, 16'h0000, 16'h0001, 16'h0002, 1'b0, 16'h0010, 16'd2, 16'd3};
    tbl[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'hBEEF, 16'hBEEF, 16'h0010, 16'h0011, 1'b1, 16'h0011, 16'd3, 16'd3};
    tbl[10] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h1111, 16'h0000, 16'h0010, 16'h0011, 1'b0, 16'h0011, 16'd3, 16'd4};
    tbl[11] = '{1'b1, 1'b1, 16'h0200, 1'b0, 16'h2222, 16'h0000, 16'h0010, 16'h0011, 1'b0, 16'h0200, 16'd3, 16'd4};
    tbl[12] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0C0C, 16'h0C0C, 16'h0200, 16'h0201, 1'b1, 16'h0201, 16'd4, 16'd4};

    rst = 1'b1; stall = 1'b0; jump = 1'b0; jump_target = 16'h0; i_hit = 1'b0;
    instr_i = 16'h0; perf_clr = 1'b0;
    m0 = mdl_reset(16'h0000);
    m1 = mdl_reset(16'hFFFF);
    step();
    step();
    chk_reset_vals();
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      stall = tbl[i].st; jump = tbl[i].jp; jump_target = tbl[i].tg;
      i_hit = tbl[i].hit; instr_i = tbl[i].din;
      step();
      chk($sformatf("vec%0d.instr_id", i), a_instr, tbl[i].e_instr);
      chk($sformatf("vec%0d.pc_id", i), a_pcid, tbl[i].e_pcid);
      chk($sformatf("vec%0d.pc_plus1_id", i), a_pp1, tbl[i].e_pp1);
      chk($sformatf("vec%0d.valid_id", i), {15'd0, a_valid}, {15'd0, tbl[i].e_valid});
      chk($sformatf("vec%0d.i_addr", i), a_addr, tbl[i].e_addr);
`ifdef IF_PERF_CNT_EN
      chk($sformatf("vec%0d.fetch_cnt", i), a_fcnt, tbl[i].e_fetch);
      chk($sformatf("vec%0d.miss_cnt", i), a_mcnt, tbl[i].e_miss);
`endif
    end

    // Async reset asserted between edges while missing.
    stall = 1'b0; jump = 1'b0; i_hit = 1'b0;
    step();
    step();
    #2 rst = 1'b1;
    #1;
    chk_reset_vals();
    step();
    rst = 1'b0;

    // PC wrap on the RESET_PC=0xFFFF instance: boot, then first hit at 0xFFFF.
    i_hit = 1'b1; instr_i = 16'hA1A1;
    step();
    instr_i = 16'hB2B2;
    step();
    chk("wrap.pc_id", w_pcid, 16'hFFFF);
    chk("wrap.pc_plus1_id", w_pp1, 16'h0000);
    chk("wrap.i_addr", w_addr, 16'h0000);
    chk("wrap.instr_id", w_instr, 16'hB2B2);

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      stall       = ($urandom_range(0, 3) == 0);
      jump        = ($urandom_range(0, 9) == 0);
      jump_target = 16'($urandom);
      i_hit       = ($urandom_range(0, 9) < 7);
      instr_i     = 16'($urandom);
`ifdef IF_PERF_CNT_EN
      perf_clr    = ($urandom_range(0, 49) == 0);
`endif
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
